// File: rtl/exec_req_arbiter.sv
// Round-robin arbiter sharing one FIFO/LIFO execute unit between NREQ requesters.
// Define EXEC_ARB_TURNAROUND_EN to insert an idle TURN cycle whenever the FIFO/LIFO mode changes.
module exec_req_arbiter #(
  parameter int NREQ = 2,
  parameter int SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [SIZE*NREQ-1:0] req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      resp_valid,
  output logic [SIZE-1:0]      resp_data,
  output logic                 resp_err,
  output logic [3:0]           exec_opcode,
  output logic [SIZE-1:0]      exec_dataIn,
  input  logic [SIZE-1:0]      exec_dataOut,
  input  logic                 exec_full,
  input  logic                 exec_empty
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [3:0] OP_BUF = 4'b0100;
  localparam logic [3:0] OP_FWR = 4'b1001;
  localparam logic [3:0] OP_FRD = 4'b1010;
  localparam logic [3:0] OP_LWR = 4'b1101;
  localparam logic [3:0] OP_LRD = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE
`ifdef EXEC_ARB_TURNAROUND_EN
    , TURN
`endif
  } state_t;

  state_t            state, state_next;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win_idx;
  logic [3:0]        win_op;
  logic [SIZE-1:0]   win_data;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     cand;
  logic              pick_found;
  logic [NREQ-1:0]   grant_vec;
  logic              is_buf, is_write, is_read, is_legal;
  logic [3:0]        ops   [NREQ];
  logic [SIZE-1:0]   datas [NREQ];
`ifdef EXEC_ARB_TURNAROUND_EN
  logic [1:0]        last_mode;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign ops[g]   = req_op[4*g +: 4];
    assign datas[g] = req_data[SIZE*g +: SIZE];
  end

  // First requesting index at or above the pointer, wrapping at NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    cand       = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
      cand = (cand == PW'(NREQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    is_buf   = (win_op == OP_BUF);
    is_write = (win_op == OP_FWR) || (win_op == OP_LWR);
    is_read  = (win_op == OP_FRD) || (win_op == OP_LRD);
    is_legal = is_buf || is_write || is_read;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = ISSUE;
`ifdef EXEC_ARB_TURNAROUND_EN
          if (last_mode != 2'b00 && ops[pick_idx][3:2] != last_mode) state_next = TURN;
`endif
        end
      end
      ISSUE: state_next = IDLE;
`ifdef EXEC_ARB_TURNAROUND_EN
      TURN:  state_next = ISSUE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      win_idx    <= '0;
      win_op     <= '0;
      win_data   <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
`ifdef EXEC_ARB_TURNAROUND_EN
      last_mode  <= 2'b00;
`endif
    end else begin
      state      <= state_next;
      resp_valid <= '0;
      if (state == IDLE && pick_found) begin
        win_idx  <= pick_idx;
        win_op   <= ops[pick_idx];
        win_data <= datas[pick_idx];
      end
      // Blocked writes and reads of an empty unit are still issued; only the response flags them.
      if (state == ISSUE) begin
        resp_valid <= grant_vec;
        resp_data  <= (is_read || is_buf) ? exec_dataOut : '0;
        resp_err   <= (is_write && exec_full) || (is_read && exec_empty) || !is_legal;
        ptr        <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`ifdef EXEC_ARB_TURNAROUND_EN
        last_mode  <= win_op[3:2];
`endif
      end
    end
  end

  assign grant_vec   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  assign gnt         = (state == ISSUE) ? grant_vec : '0;
  assign exec_opcode = (state == ISSUE && is_legal) ? win_op : 4'b0000;
  assign exec_dataIn = (state == ISSUE) ? win_data : '0;

endmodule

// File: tb/tb_exec_req_arbiter.sv
// Self-checking bench for exec_req_arbiter: vector table, directed corner cases and
// randomized traffic against a queue-based reference model of the execute unit.
module tb_exec_req_arbiter;

  localparam int NREQ = 3;
  localparam int SIZE = 8;
`ifdef EXEC_ARB_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [4*NREQ-1:0]    req_op;
  logic [SIZE*NREQ-1:0] req_data;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      resp_valid;
  logic [SIZE-1:0]      resp_data;
  logic                 resp_err;
  logic [3:0]           exec_opcode;
  logic [SIZE-1:0]      exec_dataIn;
  logic [SIZE-1:0]      exec_dataOut;
  logic                 exec_full;
  logic                 exec_empty;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exec_req_arbiter #(.NREQ(NREQ), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_data(req_data),
    .gnt(gnt), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .exec_opcode(exec_opcode), .exec_dataIn(exec_dataIn), .exec_dataOut(exec_dataOut),
    .exec_full(exec_full), .exec_empty(exec_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Four-entry execute unit: writes append, FIFO read takes the oldest, LIFO read the newest.
  logic [SIZE-1:0] mem [4];
  logic [2:0]      cnt;
  assign exec_full  = (cnt == 3'd4);
  assign exec_empty = (cnt == 3'd0);

  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= 3'd0;
    else begin
      case (exec_opcode)
        4'b1001, 4'b1101: if (cnt != 3'd4) begin
          mem[cnt[1:0]] <= exec_dataIn;
          cnt <= cnt + 3'd1;
        end
        4'b1010: if (cnt != 3'd0) begin
          mem[0] <= mem[1]; mem[1] <= mem[2]; mem[2] <= mem[3];
          cnt <= cnt - 3'd1;
        end
        4'b1110: if (cnt != 3'd0) cnt <= cnt - 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    exec_dataOut = '0;
    case (exec_opcode)
      4'b0100: exec_dataOut = exec_dataIn;
      4'b1010: if (cnt != 3'd0) exec_dataOut = mem[0];
      4'b1110: if (cnt != 3'd0) exec_dataOut = mem[cnt[1:0] - 2'd1];
      default: ;
    endcase
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [3:0] op, input logic [SIZE-1:0] data, input logic on);
    req[idx] = on;
    req_op[4*idx +: 4] = op;
    req_data[SIZE*idx +: SIZE] = data;
  endtask

  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL gnt_timeout actual=no grant required=grant within 8 cycles");
    end
  endtask

  task automatic pulse_reset();
    req = '0; req_op = '0; req_data = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model
  logic [SIZE-1:0] sq [$];
  logic [3:0]      cur_op   [NREQ];
  logic [SIZE-1:0] cur_data [NREQ];
  int              ptr_m;
  logic [1:0]      lmode_m;

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'b0100, 4'b1001, 4'b1010, 4'b1101, 4'b1110};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int gap_for(input int w);
    if (TURN_EN && lmode_m != 2'b00 && cur_op[w][3:2] != lmode_m) return 3;
    return 2;
  endfunction

  task automatic model_exec(input logic [3:0] op, input logic [SIZE-1:0] d,
                            output logic [SIZE-1:0] rd, output logic err);
    rd = '0;
    err = 1'b0;
    case (op)
      4'b0100: rd = d;
      4'b1001, 4'b1101: if (sq.size() == 4) err = 1'b1; else sq.push_back(d);
      4'b1010: if (sq.size() == 0) err = 1'b1; else rd = sq.pop_front();
      4'b1110: if (sq.size() == 0) err = 1'b1; else rd = sq.pop_back();
      default: err = 1'b1;
    endcase
  endtask

  task automatic new_req(input int i);
    logic [3:0] op;
    case ($urandom_range(0, 9))
      0, 1:    op = 4'b1001;
      2, 3:    op = 4'b1101;
      4, 5:    op = 4'b1010;
      6, 7:    op = 4'b1110;
      8:       op = 4'b0100;
      default: case ($urandom_range(0, 2))
                 0:       op = 4'b0011;
                 1:       op = 4'b1111;
                 default: op = 4'b0000;
               endcase
    endcase
    cur_op[i]   = op;
    cur_data[i] = SIZE'($urandom);
    applyStimulus(i, op, cur_data[i], 1'b1);
  endtask

  typedef struct packed {
    logic [3:0]      op;
    logic [SIZE-1:0] data;
    logic [3:0]      exp_opcode;
    logic [SIZE-1:0] exp_resp;
    logic            exp_err;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic ok;
    int   idx, tprev, w, since, exp_gap;
    logic resp_pend, stalled;
    logic [NREQ-1:0] exp_rv;
    logic [SIZE-1:0] exp_rd;
    logic            exp_re;

    vecs[0]  = '{4'b1001, 8'hA1, 4'b1001, 8'h00, 1'b0};
    vecs[1]  = '{4'b1001, 8'hB2, 4'b1001, 8'h00, 1'b0};
    vecs[2]  = '{4'b1010, 8'h00, 4'b1010, 8'hA1, 1'b0};
    vecs[3]  = '{4'b1010, 8'h00, 4'b1010, 8'hB2, 1'b0};
    vecs[4]  = '{4'b1110, 8'h00, 4'b1110, 8'h00, 1'b1};
    vecs[5]  = '{4'b0100, 8'h5C, 4'b0100, 8'h5C, 1'b0};
    vecs[6]  = '{4'b0011, 8'h77, 4'b0000, 8'h00, 1'b1};
    vecs[7]  = '{4'b1101, 8'h11, 4'b1101, 8'h00, 1'b0};
    vecs[8]  = '{4'b1101, 8'h22, 4'b1101, 8'h00, 1'b0};
    vecs[9]  = '{4'b1101, 8'h33, 4'b1101, 8'h00, 1'b0};
    vecs[10] = '{4'b1101, 8'h44, 4'b1101, 8'h00, 1'b0};
    vecs[11] = '{4'b1101, 8'h55, 4'b1101, 8'h00, 1'b1};
    vecs[12] = '{4'b1110, 8'h00, 4'b1110, 8'h44, 1'b0};
    vecs[13] = '{4'b1010, 8'h00, 4'b1010, 8'h11, 1'b0};
    vecs[14] = '{4'b1110, 8'h00, 4'b1110, 8'h33, 1'b0};
    vecs[15] = '{4'b1010, 8'h00, 4'b1010, 8'h22, 1'b0};

    reset = 1'b1;
    req = '0; req_op = '0; req_data = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_data", 32'(resp_data), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_exec_opcode", 32'(exec_opcode), 32'd0);
    checkOutput("rst_exec_dataIn", 32'(exec_dataIn), 32'd0);
    reset = 1'b0;

    // Vector table, one requester at a time
    for (int i = 0; i < 16; i++) begin
      idx = i % NREQ;
      applyStimulus(idx, vecs[i].op, vecs[i].data, 1'b1);
      wait_gnt(ok);
      if (ok) begin
        checkOutput($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(1 << idx));
        checkOutput($sformatf("tbl%0d_opcode", i), 32'(exec_opcode), 32'(vecs[i].exp_opcode));
        checkOutput($sformatf("tbl%0d_dataIn", i), 32'(exec_dataIn), 32'(vecs[i].data));
        applyStimulus(idx, 4'b0000, '0, 1'b0);
        @(negedge clk);
        checkOutput($sformatf("tbl%0d_resp_valid", i), 32'(resp_valid), 32'(1 << idx));
        checkOutput($sformatf("tbl%0d_resp_data", i), 32'(resp_data), 32'(vecs[i].exp_resp));
        checkOutput($sformatf("tbl%0d_resp_err", i), 32'(resp_err), 32'(vecs[i].exp_err));
        checkOutput($sformatf("tbl%0d_gnt_low", i), 32'(gnt), 32'd0);
      end
      applyStimulus(idx, 4'b0000, '0, 1'b0);
    end

    // Reset asserted during ISSUE
    applyStimulus(0, 4'b1001, 8'h99, 1'b1);
    wait_gnt(ok);
    checkOutput("midrst_pre_gnt", 32'(gnt), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_gnt", 32'(gnt), 32'd0);
    checkOutput("midrst_opcode", 32'(exec_opcode), 32'd0);
    checkOutput("midrst_dataIn", 32'(exec_dataIn), 32'd0);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
    applyStimulus(0, 4'b0000, '0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("midrst_post_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("midrst_post_gnt", 32'(gnt), 32'd0);
    end

    // Two requesters held high: alternate grants, one every two cycles
    applyStimulus(0, 4'b1001, 8'h10, 1'b1);
    applyStimulus(1, 4'b1001, 8'h20, 1'b1);
    tprev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(ok);
      if (!ok) break;
      checkOutput($sformatf("cont%0d_gnt", g), 32'(gnt), 32'(1 << (g % 2)));
      if (g > 0) checkOutput($sformatf("cont%0d_gap", g), 32'(cyc - tprev), 32'd2);
      tprev = cyc;
      @(negedge clk);
      checkOutput($sformatf("cont%0d_resp_valid", g), 32'(resp_valid), 32'(1 << (g % 2)));
    end
    pulse_reset();

    // FIFO write followed by LIFO read: mode change
    applyStimulus(0, 4'b1001, 8'h3C, 1'b1);
    wait_gnt(ok);
    tprev = cyc;
    applyStimulus(0, 4'b1110, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("turn_wr_err", 32'(resp_err), 32'd0);
    checkOutput("turn_idle_opcode", 32'(exec_opcode), 32'd0);
    wait_gnt(ok);
    checkOutput("turn_gap", 32'(cyc - tprev), TURN_EN ? 32'd3 : 32'd2);
    checkOutput("turn_rd_opcode", 32'(exec_opcode), 32'b1110);
    applyStimulus(0, 4'b0000, '0, 1'b0);
    @(negedge clk);
    checkOutput("turn_rd_data", 32'(resp_data), 32'h3C);
    checkOutput("turn_rd_err", 32'(resp_err), 32'd0);
    pulse_reset();

    // Randomized traffic against the reference model
    sq.delete();
    ptr_m = 0;
    lmode_m = 2'b00;
    for (int i = 0; i < NREQ; i++) begin
      cur_op[i] = '0;
      cur_data[i] = '0;
    end
    resp_pend = 1'b0;
    stalled = 1'b0;
    since = 0;
    exp_gap = 0;
    exp_rv = '0; exp_rd = '0; exp_re = 1'b0;
    for (int n = 0; n < 600 && !stalled; n++) begin
      @(negedge clk);
      since++;
      if (resp_pend) begin
        checkOutput("rnd_resp_valid", 32'(resp_valid), 32'(exp_rv));
        checkOutput("rnd_resp_data", 32'(resp_data), 32'(exp_rd));
        checkOutput("rnd_resp_err", 32'(resp_err), 32'(exp_re));
        resp_pend = 1'b0;
      end else begin
        checkOutput("rnd_resp_quiet", 32'(resp_valid), 32'd0);
      end
      if (gnt != '0) begin
        w = rr_pick(req, ptr_m);
        checkOutput("rnd_gnt", 32'(gnt), (w < 0) ? 32'd0 : 32'(1 << w));
        if (w < 0) w = 0;
        checkOutput("rnd_opcode", 32'(exec_opcode), is_legal(cur_op[w]) ? 32'(cur_op[w]) : 32'd0);
        checkOutput("rnd_dataIn", 32'(exec_dataIn), 32'(cur_data[w]));
        if (exp_gap != 0) checkOutput("rnd_gap", 32'(since), 32'(exp_gap));
        model_exec(cur_op[w], cur_data[w], exp_rd, exp_re);
        exp_rv = NREQ'(1 << w);
        resp_pend = 1'b1;
        ptr_m = (w + 1) % NREQ;
        lmode_m = cur_op[w][3:2];
        if ($urandom_range(0, 2) != 0) new_req(w);
        else applyStimulus(w, 4'b0000, '0, 1'b0);
        for (int i = 0; i < NREQ; i++) begin
          if (i != w && !req[i] && $urandom_range(0, 3) == 0) new_req(i);
        end
        since = 0;
        exp_gap = (req != '0) ? gap_for(rr_pick(req, ptr_m)) : 0;
      end else begin
        checkOutput("rnd_idle_opcode", 32'(exec_opcode), 32'd0);
        checkOutput("rnd_idle_dataIn", 32'(exec_dataIn), 32'd0);
        if (req == '0) begin
          since = 0;
          exp_gap = 0;
          for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 1) == 0) new_req(i);
          end
        end else if (since > 4) begin
          checks++;
          errors++;
          $display("[TB] FAIL rnd_stall actual=%0d idle cycles required=at most 3", since);
          stalled = 1'b1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
